// File: rtl/slicem_pkg.sv
// Shared types and geometry helpers for the slicem LUT-RAM write/readback blocks.
package slicem_pkg;

    localparam int S_XX_BASE_DEF = 4;
    localparam int NUM_LUTS_DEF  = 4;
    localparam int MUX_LVLS_DEF  = $clog2(NUM_LUTS_DEF);
    localparam int WORD_W_DEF    = 8;

    // Bit-address width: LUT address bits, one LUT-half select bit, then the LUT mux levels.
    function automatic int calc_addr_w(input int s_xx_base, input int num_luts);
        return s_xx_base + 1 + $clog2(num_luts);
    endfunction

    localparam int ADDR_W_DEF = calc_addr_w(S_XX_BASE_DEF, NUM_LUTS_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic [MUX_LVLS_DEF-1:0]  hi;
        logic                     sel;
        logic [S_XX_BASE_DEF-1:0] lo;
    } addr_fields_t;

    // Split a default-geometry bit address into {hi, sel, lo}.
    function automatic addr_fields_t split_addr(input logic [ADDR_W_DEF-1:0] bit_addr);
        return addr_fields_t'(bit_addr);
    endfunction

endpackage

// File: rtl/slicem_addr_split.sv
// Combinational split of a slice bit address into the slice's address ports.
// The low field is replicated into every LUT input slot of luts_in.
module slicem_addr_split
    import slicem_pkg::*;
#(
    parameter int S_XX_BASE = S_XX_BASE_DEF,
    parameter int NUM_LUTS  = NUM_LUTS_DEF,
    parameter int MUX_LVLS  = $clog2(NUM_LUTS),
    parameter int ADDR_W    = S_XX_BASE + 1 + MUX_LVLS
) (
    input  logic [ADDR_W-1:0]               bit_addr,
    output logic [MUX_LVLS-1:0]             higher_order_addr,
    output logic                            write_lut_select,
    output logic [NUM_LUTS*2*S_XX_BASE-1:0] luts_in
);

    assign higher_order_addr = bit_addr[ADDR_W-1 -: MUX_LVLS];
    assign write_lut_select  = bit_addr[S_XX_BASE];
    assign luts_in           = {(NUM_LUTS*2){bit_addr[S_XX_BASE-1:0]}};

endmodule

// File: rtl/slicem_ram_writer.sv
// Serializes word-wide host write requests into the slicem single-bit LUT-RAM
// write protocol, one bit slot per clock, stalling while cfg_busy is high.
//
// state | meaning
// IDLE  | req_ready high; capture request on req_valid
// WRITE | drive one bit slot per non-stalled cycle, WORD_W slots total
// DONE  | schedule the one-cycle done pulse, then back to IDLE
module slicem_ram_writer
    import slicem_pkg::*;
#(
    parameter int S_XX_BASE = S_XX_BASE_DEF,
    parameter int NUM_LUTS  = NUM_LUTS_DEF,
    parameter int MUX_LVLS  = $clog2(NUM_LUTS),
    parameter int WORD_W    = WORD_W_DEF,
    parameter int ADDR_W    = calc_addr_w(S_XX_BASE, NUM_LUTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [WORD_W-1:0]               req_data,
    input  logic [WORD_W-1:0]               req_mask,
    input  logic                            cfg_busy,
    output logic                            done,
    output logic                            busy,
    output logic                            data_in,
    output logic                            write_en,
    output logic                            write_lut_select,
    output logic [MUX_LVLS-1:0]             higher_order_addr,
    output logic [NUM_LUTS*2*S_XX_BASE-1:0] luts_in
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    wr_state_t          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  cap_addr_q, cap_addr_d;
    logic [WORD_W-1:0]  cap_data_q, cap_data_d;
    logic [WORD_W-1:0]  cap_mask_q, cap_mask_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               data_q, data_d;
    logic               wen_q, wen_d;
    logic               done_q, done_d;

    // State, capture and registered slice outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            cap_mask_q <= '0;
            addr_q     <= '0;
            data_q     <= 1'b0;
            wen_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            cap_mask_q <= cap_mask_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wen_q      <= wen_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic; address/data hold unless a slot is driven.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        cap_mask_d = cap_mask_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wen_d      = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cap_addr_d = req_addr;
                    cap_data_d = req_data;
                    cap_mask_d = req_mask;
                    idx_d      = '0;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (!cfg_busy) begin
                    addr_d = cap_addr_q + ADDR_W'(idx_q);
                    data_d = cap_data_q[idx_q];
                    wen_d  = cap_mask_q[idx_q];
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign data_in   = data_q;
    assign write_en  = wen_q;
    assign done      = done_q;

    slicem_addr_split #(
        .S_XX_BASE (S_XX_BASE),
        .NUM_LUTS  (NUM_LUTS),
        .MUX_LVLS  (MUX_LVLS),
        .ADDR_W    (ADDR_W)
    ) u_addr_split (
        .bit_addr          (addr_q),
        .higher_order_addr (higher_order_addr),
        .write_lut_select  (write_lut_select),
        .luts_in           (luts_in)
    );

endmodule

// File: doc/slicem_ram_writer.md
Name: slicem_ram_writer

Overview:
- Write-side initiator for the memory logic slice's LUT-RAM port: accepts word-wide write requests from a host over valid/ready and serializes them into the slice's single-bit write protocol.
- Drives data_in, write_en, write_lut_select, higher_order_addr and the replicated luts_in address, one bit per clock.
- Sits between the fabric-level memory controller and one slicem instance; stalls while the slice's configuration chain is active.

Parameters:
- S_XX_BASE, 4, LUT base input count; low bit-address field width.
- NUM_LUTS, 4, LUTs per slice (power of 2).
- MUX_LVLS, $clog2(NUM_LUTS), width of the LUT-select field.
- WORD_W, 8, bits per host request (1..2**ADDR_W).
- ADDR_W, S_XX_BASE+1+MUX_LVLS, bit-address width (7 by default, 128 bits per slice).

Ports:
- clk  in  1  clock; the slice's clk domain.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_W  starting bit address, {hi_addr, lut_sel, lut_addr}.
- req_data  in  WORD_W  data; bit 0 is written first.
- req_mask  in  WORD_W  per-bit enable; 0 means skip the write but still spend the cycle.
- cfg_busy  in  1  slice configuration shift in progress; stall.
- done  out  1  one-cycle pulse after the last bit slot.
- busy  out  1  high in WRITE and DONE.
- data_in  out  1  bit to the slice.
- write_en  out  1  slice write strobe.
- write_lut_select  out  1  address bit S_XX_BASE.
- higher_order_addr  out  MUX_LVLS  address bits [ADDR_W-1 -: MUX_LVLS].
- luts_in  out  NUM_LUTS*2*S_XX_BASE  address bits [S_XX_BASE-1:0], replicated across every LUT input slot.

Behaviour:
- Reset, asynchronous with rst_n low:
  - state goes to IDLE.
  - All outputs go to 0 except req_ready, which is 1.
  - The bit counter and captured request clear.
  - Reset in the middle of a word abandons it. Bits already written stay written, and there is no resume.
- States are IDLE, WRITE and DONE.
- IDLE:
  - req_ready is 1.
  - When req_valid is high, req_addr, req_data and req_mask are captured, idx is set to 0, and the state moves to WRITE.
- WRITE:
  - Each non-stalled cycle drives one bit slot, with all outputs registered:
    - address = (cap_addr + idx) mod 2**ADDR_W
    - data_in = cap_data[idx]
    - write_en = cap_mask[idx]
  - idx increments after each slot. After slot WORD_W-1 the state moves to DONE.
- Stall:
  - While cfg_busy is high, write_en is forced to 0 in that cycle and idx does not advance.
  - Address and data_in hold their values.
  - cfg_busy sampled high in IDLE does not block acceptance. The first slot then waits until cfg_busy drops.
- DONE:
  - done is 1 for exactly one cycle, write_en is 0, then the state returns to IDLE.
- Latency:
  - The accept edge is cycle 0. The first write_en is visible in cycle 1.
  - With no stalls, the last slot is in cycle WORD_W and done is in cycle WORD_W+1.
  - Minimum spacing between accepts is WORD_W+2 cycles.
- Address wrap: incrementing past 2**ADDR_W-1 wraps to 0 within the same request, with no error.
- All-zero mask: WORD_W slots run with write_en kept at 0, and done still pulses.
- req_valid while not in IDLE is ignored, because req_ready is 0. The host must hold the request.
- Between requests, address and data outputs hold their last values and write_en is 0.

Decomposition:
- Shared package slicem_pkg holds:
  - a localparam for ADDR_W derivation;
  - the state enum typedef (IDLE, WRITE, DONE);
  - an address-split helper that returns {hi, sel, lo} fields.
- One sub-module, slicem_addr_split: combinational split of a bit address into higher_order_addr, write_lut_select, and the replicated luts_in bus. It is reused by the future readback block.

Test Plan:
- Single word:
  - Stimulus: req_addr=7'h00, req_data=8'hA5, req_mask=8'hFF, no stall.
  - Expected: write_en high in cycles 1..8; data_in sequence 1,0,1,0,0,1,0,1; addresses 0..7; done in cycle 9.
  - Slice readback returns A5.
- Wrap:
  - Stimulus: req_addr=7'h7E, WORD_W=8.
  - Expected: address sequence 7E,7F,00,01..05; higher_order_addr goes 3→0 at the third slot; write_lut_select goes 1→0.
- Mask:
  - Stimulus: req_mask=8'h0F.
  - Expected: write_en high only in slots 0-3, and done still in cycle 9.
  - Stimulus: req_mask=8'h00.
  - Expected: zero write strobes, done in cycle 9.
- Stall:
  - Stimulus: cfg_busy high in cycles 3-5 of a word.
  - Expected: write_en low in those cycles; the address for slot 2 is held; done in cycle 12; the written data is intact.
- Back-to-back and reset:
  - Stimulus: req_valid held high continuously with two words.
  - Expected: the second accept occurs exactly 10 cycles after the first.
  - Stimulus: assert rst_n low at slot 4.
  - Expected: the outputs that reset to 0 read 0 asynchronously, req_ready reads 1, and no further write_en occurs.
  - Expected: after release, a new request completes normally.
